ram_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the write-capable port (port 2) of the 4 KiB dual-port data RAM. It accepts byte, halfword and word load/store requests from the CPU load/store unit (requester 0) and the program loader/debug master (requester 1). It grants the port round-robin, generates the low-lane-aligned byte enables the RAM expects, and returns lane-extracted, sign/zero-extended read data. Misaligned accesses are rejected without touching the RAM.

---
 rtl/ram_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter and access sequencer for the write-capable port of
//   the 4 KiB dual-port data RAM. Two requesters issue byte/half/word loads
//   and stores. Each access is sequenced IDLE -> ACCESS -> DONE. Misaligned
//   requests skip ACCESS and complete with err.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req[1:0], we[1:0]   per-requester request and store(1)/load(0)
//   size0/1             00 byte, 01 half, 10 word, 11 misaligned
//   unsigned0/1         1 = zero-extend load, 0 = sign-extend
//   addr0/1, wdata0/1   byte address, right-justified store data
//   ack[1:0], err       one-cycle completion pulse, misaligned flag
//   rdata               extended load result, held between loads
//   ram_*               RAM port 2 controls; all zero outside ACCESS
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            size0,
  input  logic [1:0]            size1,
  input  logic                  unsigned0,
  input  logic                  unsigned1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic [1:0]            ack,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  ram_chip_select,
  output logic                  ram_output_enable,
  output logic [3:0]            ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  err_pending_q, err_pending_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  // Winner selection and the winner's qualifiers
  logic                  win;
  logic                  sel_we;
  logic [1:0]            sel_size;
  logic                  sel_uns;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic                  sel_aligned;

  // Load lane extraction from the combinational RAM read data
  logic [31:0]           rd_shifted;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;

  always_comb begin
    // On contention the requester that did not win last time goes first.
    win       = (req == 2'b11) ? ~last_grant_q : req[1];
    sel_we    = win ? we[1]     : we[0];
    sel_size  = win ? size1     : size0;
    sel_uns   = win ? unsigned1 : unsigned0;
    sel_addr  = win ? addr1     : addr0;
    sel_wdata = win ? wdata1    : wdata0;

    case (sel_size)
      2'b00:   sel_aligned = 1'b1;
      2'b01:   sel_aligned = ~sel_addr[0];
      2'b10:   sel_aligned = (sel_addr[1:0] == 2'b00);
      default: sel_aligned = 1'b0;
    endcase
  end

  always_comb begin
    rd_shifted = ram_read_data >> {addr_q[1:0], 3'b000};
    rd_half    = addr_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_val = ram_read_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    err_pending_d = err_pending_q;
    id_d          = id_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d          = win;
          last_grant_d  = win;
          we_d          = sel_we;
          size_d        = sel_size;
          uns_d         = sel_uns;
          addr_d        = sel_addr;
          wdata_d       = sel_wdata;
          err_pending_d = ~sel_aligned;
          state_d       = sel_aligned ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        if (!we_q) rdata_d = load_val;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM controls depend on registered state only; rst does not gate them,
  // so a store already in ACCESS still commits at the reset edge.
  always_comb begin
    ram_chip_select   = 1'b0;
    ram_output_enable = 1'b0;
    ram_write_enable  = '0;
    ram_addr          = '0;
    ram_write_data    = '0;
    if (state_q == S_ACCESS) begin
      ram_chip_select   = 1'b1;
      ram_addr          = addr_q;
      ram_output_enable = ~we_q;
      if (we_q) begin
        ram_write_data = wdata_q;
        case (size_q)
          2'b00:   ram_write_enable = 4'b0001;
          2'b01:   ram_write_enable = 4'b0011;
          default: ram_write_enable = 4'b1111;
        endcase
      end
    end
  end

  // A reset landing in the DONE cycle withdraws that cycle's ack.
  always_comb begin
    ack = '0;
    err = 1'b0;
    if (state_q == S_DONE && !rst) begin
      ack[id_q] = 1'b1;
      err       = err_pending_q;
    end
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      err_pending_q <= 1'b0;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      err_pending_q <= err_pending_d;
      id_q          <= id_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Drives ram_port_arbiter against a word-organised RAM model and checks
//   every completion against a byte-level reference memory, a round-robin
//   grant model and the expected cycle latencies.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [1:0]  size0, size1;
  logic        unsigned0, unsigned1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        ram_chip_select, ram_output_enable;
  logic [3:0]  ram_write_enable;
  logic [11:0] ram_addr;
  logic [31:0] ram_write_data, ram_read_data;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .size0(size0), .size1(size1),
    .unsigned0(unsigned0), .unsigned1(unsigned1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata),
    .ram_chip_select(ram_chip_select), .ram_output_enable(ram_output_enable),
    .ram_write_enable(ram_write_enable), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  // RAM port 2 model: write_data[7:0] lands at the addressed byte.
  logic [31:0] ram [1024] = '{default: '0};
  assign ram_read_data = ram[ram_addr[11:2]];
  always @(posedge clk) begin
    if (ram_chip_select) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_write_enable[k]) begin
          int ba;
          ba = int'(ram_addr) + k;
          ram[ba / 4][(ba % 4) * 8 +: 8] = ram_write_data[8 * k +: 8];
        end
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [4096] = '{default: '0};
  logic [31:0] ref_rdata;
  int          ref_last;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_load(input int a, input int sz, input bit un);
    logic [31:0] v;
    int nb;
    v  = '0;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    for (int k = 0; k < nb; k++) v[8 * k +: 8] = ref_mem[(a + k) % 4096];
    if (!un && sz == 0 && v[7])  v[31:8]  = '1;
    if (!un && sz == 1 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic bit misaligned(input int a, input int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ref_rdata = '0;
    ref_last  = 1;
  endtask

  task automatic access(input int id, input bit w, input int sz, input bit un,
                        input int a, input logic [31:0] wd,
                        output logic [31:0] rd);
    bit   mis, got_ack;
    int   ack_cyc, cs_cnt, cs_cyc, nb;
    logic [1:0] ack_v;
    logic       err_v;
    logic [3:0] we_seen, we_exp;
    mis = misaligned(a, sz);
    nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    if (id == 0) begin
      we[0] = w; size0 = 2'(sz); unsigned0 = un; addr0 = 12'(a); wdata0 = wd;
    end else begin
      we[1] = w; size1 = 2'(sz); unsigned1 = un; addr1 = 12'(a); wdata1 = wd;
    end
    req[id] = 1'b1;
    got_ack = 0; ack_cyc = -1; cs_cnt = 0; cs_cyc = -1; we_seen = '0;
    ack_v = '0; err_v = 1'b0; rd = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (ram_chip_select) begin
        cs_cnt++; cs_cyc = cyc; we_seen = ram_write_enable;
      end
      if (ack != 2'b00) begin
        got_ack = 1; ack_cyc = cyc; ack_v = ack; err_v = err; rd = rdata;
        req[id] = 1'b0;
        break;
      end
    end
    if (!got_ack) begin
      req[id] = 1'b0;
      check_eq("ack_timeout", 32'(got_ack), 32'd1);
    end else begin
      ref_last = id;
      check_eq("ack_id", 32'(ack_v), 32'(1 << id));
      check_eq("err", 32'(err_v), 32'(mis));
      check_eq("ack_latency", 32'(ack_cyc), mis ? 32'd1 : 32'd2);
      if (mis) begin
        check_eq("cs_on_misaligned", 32'(cs_cnt), 32'd0);
      end else begin
        we_exp = w ? ((sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111) : 4'b0000;
        check_eq("cs_cycle", 32'(cs_cyc), 32'd1);
        check_eq("write_enable", 32'(we_seen), 32'(we_exp));
        if (w) for (int k = 0; k < nb; k++) ref_mem[(a + k) % 4096] = wd[8 * k +: 8];
        else   ref_rdata = ref_load(a, sz, un);
      end
      check_eq("rdata", rd, ref_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_rdata"}, rdata, 32'd0);
    check_eq({tag, "_ram_ctl"},
             {27'd0, ram_chip_select, ram_output_enable, 1'b0, 2'b00}, 32'd0);
    check_eq({tag, "_ram_we"}, 32'(ram_write_enable), 32'd0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check_eq({tag, "_ram_wdata"}, ram_write_data, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int nack, prev_cyc, ew;
    req = '0; we = '0; size0 = '0; size1 = '0; unsigned0 = 0; unsigned1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

    // Directed sequence
    access(0, 1, 2, 0, 'h010, 32'hDEADBEEF, rd);
    access(0, 0, 2, 0, 'h010, 32'h0, rd);
    check_eq("plan_word_load", rd, 32'hDEADBEEF);
    access(0, 1, 0, 0, 'h013, 32'h000000A5, rd);
    access(0, 0, 0, 0, 'h013, 32'h0, rd);
    check_eq("plan_byte_signed", rd, 32'hFFFFFFA5);
    access(0, 0, 0, 1, 'h013, 32'h0, rd);
    check_eq("plan_byte_unsigned", rd, 32'h000000A5);
    access(0, 0, 2, 0, 'h010, 32'h0, rd);
    check_eq("plan_word_merged", rd, 32'hA5ADBEEF);
    access(0, 0, 1, 0, 'h012, 32'h0, rd);
    check_eq("plan_half_signed", rd, 32'hFFFFA5AD);
    access(0, 0, 1, 0, 'h011, 32'h0, rd);
    check_eq("plan_half_misaligned_hold", rd, 32'hFFFFA5AD);

    // Randomized single-requester traffic in a small window
    for (int i = 0; i < 80; i++) begin
      access(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 63)), $urandom, rd);
    end

    // Contention: both hold word loads; grants alternate every 3 cycles
    do_reset();
    we = 2'b00; size0 = 2'b10; size1 = 2'b10; unsigned0 = 0; unsigned1 = 0;
    addr0 = 12'h010; addr1 = 12'h030;
    req = 2'b11;
    nack = 0; prev_cyc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        ew = 1 - ref_last;
        ref_last = ew;
        ref_rdata = ref_load((ew == 0) ? 'h010 : 'h030, 2, 0);
        check_eq("arb_grant", 32'(ack), 32'(1 << ew));
        check_eq("arb_rdata", rdata, ref_rdata);
        check_eq("arb_spacing", 32'(cyc), (nack == 0) ? 32'd2 : 32'(prev_cyc + 3));
        prev_cyc = cyc;
        nack++;
        if (nack == 4) begin
          req = 2'b00;
          break;
        end
      end
    end
    req = 2'b00;
    check_eq("arb_grant_count", 32'(nack), 32'd4);
    @(posedge clk); #1;

    // Reset in the ACCESS cycle of a store: write commits, no ack
    we[0] = 1; size0 = 2'b10; unsigned0 = 0; addr0 = 12'h020; wdata0 = 32'h12345678;
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_access_cs", 32'(ram_chip_select), 32'd1);
    rst = 1'b1;
    req = 2'b00;
    for (int k = 0; k < 4; k++) ref_mem['h020 + k] = wdata0[8 * k +: 8];
    ref_rdata = '0;
    ref_last  = 1;
    @(negedge clk);
    check_idle_outputs("rst_after_access");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_no_late_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    access(0, 0, 2, 0, 'h020, 32'h0, rd);
    check_eq("rst_store_committed", rd, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
